array_element_reader: RTL and testbench

Streaming reader for the flattened register-file array produced by the array writer block. On a start pulse it snapshots the whole flattened array, then emits one element per accepted handshake in ascending index order, tagging each with its index and a last flag. While streaming it accumulates the bitwise OR of all emitted elements and presents the result on completion. It sits between the register file and any serial consumer: a bus bridge, a debug dump port, or a reduction stage.

---
 rtl/array_element_reader.sv | 116 +++++++++++
 tb/tb_array_element_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_element_reader.sv
// Streaming reader for a flattened register-file array.
// A start pulse snapshots the whole array, then one element is emitted per accepted
// handshake in ascending index order. The OR of every emitted element is published
// on or_result when the final element transfers.
module array_element_reader #(
    parameter int unsigned ELEMENTS = 16,
    parameter int unsigned WIDTH    = 32
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic [ELEMENTS*WIDTH-1:0]   array,
    input  logic                        start,
    input  logic                        ready,
    output logic                        valid,
    output logic [WIDTH-1:0]            element,
    output logic [$clog2(ELEMENTS)-1:0] index,
    output logic                        last,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            or_result
);

    localparam int unsigned IdxW = $clog2(ELEMENTS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(ELEMENTS - 1);

    typedef enum logic {
        StIdle,
        StStream
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  or_q, or_d;
    logic              done_q, done_d;
    logic              capture;
    logic [WIDTH-1:0]  snap_q [ELEMENTS];
    logic [WIDTH-1:0]  cur_elem;

    // Element currently addressed in the snapshot.
    assign cur_elem = snap_q[idx_q];

    // Next-state logic: capture on start, advance on each accepted transfer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        or_d    = or_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (ready) begin
                    acc_d = acc_q | cur_elem;
                    if (idx_q == LastIdx) begin
                        // Publish the accumulator including the final element.
                        or_d    = acc_q | cur_elem;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result registers; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            or_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            or_q    <= or_d;
            done_q  <= done_d;
        end
    end

    // Snapshot registers, loaded only when a stream is accepted.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < int'(ELEMENTS); i++) begin
                snap_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < int'(ELEMENTS); i++) begin
                snap_q[i] <= array[i*WIDTH +: WIDTH];
            end
        end
    end

    assign valid     = (state_q == StStream);
    assign busy      = valid;
    assign element   = valid ? cur_elem : '0;
    assign index     = valid ? idx_q : '0;
    assign last      = valid && (idx_q == LastIdx);
    assign done      = done_q;
    assign or_result = or_q;

endmodule

// File: tb/tb_array_element_reader.sv
// Directed bench for array_element_reader with ELEMENTS=4, WIDTH=8.
// Observed outputs are packed as {valid,busy,done,last,index,element,or_result}.
module tb_array_element_reader;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] array;
    logic        start;
    logic        ready;
    logic        valid;
    logic [7:0]  element;
    logic [1:0]  index;
    logic        last;
    logic        busy;
    logic        done;
    logic [7:0]  or_result;

    logic [21:0] obs;
    logic [21:0] exp_v;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  el_a [4];
    logic [7:0]  el_b [4];

    assign obs = {valid, busy, done, last, index, element, or_result};

    array_element_reader #(
        .ELEMENTS(4),
        .WIDTH   (8)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .array    (array),
        .start    (start),
        .ready    (ready),
        .valid    (valid),
        .element  (element),
        .index    (index),
        .last     (last),
        .busy     (busy),
        .done     (done),
        .or_result(or_result)
    );

    initial forever #5 clock = ~clock;

    // Advance one cycle and settle just past the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        array = $urandom;
        start = 1'b1;
        ready = 1'b1;
        step();
        array = $urandom;
        ready = 1'b0;
        step();
        n_cmp++;
        if (obs !== 22'h0) begin
            $display("FAIL reset_outputs: got %h want %h", obs, 22'h0);
            n_err++;
        end
        // clear and start together: clear wins.
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (obs !== 22'h0) begin
            $display("FAIL clear_beats_start: got %h want %h", obs, 22'h0);
            n_err++;
        end
        step();
        step();
        n_cmp++;
        if (valid !== 1'b0) begin
            $display("FAIL idle_no_start: got valid=%b want 0", valid);
            n_err++;
        end
    endtask

    task automatic test_full_stream();
        array = 32'h44332211;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = {1'b1, 1'b1, 1'b0, (k == 3), 2'(k), el_a[k], 8'h00};
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL full_elem%0d: got %h want %h", k, obs, exp_v);
                n_err++;
            end
            step();
        end
        exp_v = {4'b0010, 2'd0, 8'h00, 8'h77};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL full_done: got %h want %h", obs, exp_v);
            n_err++;
        end
        step();
        exp_v = {4'b0000, 2'd0, 8'h00, 8'h77};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL full_after_done: got %h want %h", obs, exp_v);
            n_err++;
        end
    endtask

    task automatic test_backpressure();
        clear = 1'b1;
        step();
        clear = 1'b0;
        array = 32'h44332211;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_v = {4'b1100, 2'd1, 8'h22, 8'h00};
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL bp_hold%0d: got %h want %h", i, obs, exp_v);
                n_err++;
            end
            step();
        end
        ready = 1'b1;
        exp_v = {4'b1100, 2'd1, 8'h22, 8'h00};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL bp_release: got %h want %h", obs, exp_v);
            n_err++;
        end
        step();
        exp_v = {4'b1100, 2'd2, 8'h33, 8'h00};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL bp_resume: got %h want %h", obs, exp_v);
            n_err++;
        end
        step();
        step();
        exp_v = {4'b0010, 2'd0, 8'h00, 8'h77};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL bp_done: got %h want %h", obs, exp_v);
            n_err++;
        end
    endtask

    task automatic test_snapshot();
        array = 32'h44332211;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        array = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            exp_v = {1'b1, 1'b1, 1'b0, (k == 3), 2'(k), el_a[k], 8'h77};
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL snap_elem%0d: got %h want %h", k, obs, exp_v);
                n_err++;
            end
            start = (k == 0);
            step();
            start = 1'b0;
        end
        exp_v = {4'b0010, 2'd0, 8'h00, 8'h77};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL snap_done: got %h want %h", obs, exp_v);
            n_err++;
        end
        step();
        n_cmp++;
        if (valid !== 1'b0) begin
            $display("FAIL snap_no_restart: got valid=%b want 0", valid);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        array = 32'h44332211;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        exp_v = {4'b0010, 2'd0, 8'h00, 8'h77};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL b2b_first_done: got %h want %h", obs, exp_v);
            n_err++;
        end
        array = 32'h08040201;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = {1'b1, 1'b1, 1'b0, (k == 3), 2'(k), el_b[k], 8'h77};
            n_cmp++;
            if (obs !== exp_v) begin
                $display("FAIL b2b_elem%0d: got %h want %h", k, obs, exp_v);
                n_err++;
            end
            step();
        end
        exp_v = {4'b0010, 2'd0, 8'h00, 8'h0F};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL b2b_done: got %h want %h", obs, exp_v);
            n_err++;
        end
        step();
    endtask

    task automatic test_clear_mid();
        int seen_done;
        seen_done = 0;
        array = 32'h44332211;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        exp_v = {4'b1100, 2'd2, 8'h33, 8'h0F};
        n_cmp++;
        if (obs !== exp_v) begin
            $display("FAIL clr_pre: got %h want %h", obs, exp_v);
            n_err++;
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_cmp++;
        if (obs !== 22'h0) begin
            $display("FAIL clr_outputs: got %h want %h", obs, 22'h0);
            n_err++;
        end
        for (int i = 0; i < 6; i++) begin
            if (done !== 1'b0 || valid !== 1'b0) seen_done++;
            step();
        end
        n_cmp++;
        if (seen_done != 0) begin
            $display("FAIL clr_no_done: got %0d active cycles want 0", seen_done);
            n_err++;
        end
    endtask

    initial begin
        el_a[0] = 8'h11; el_a[1] = 8'h22; el_a[2] = 8'h33; el_a[3] = 8'h44;
        el_b[0] = 8'h01; el_b[1] = 8'h02; el_b[2] = 8'h04; el_b[3] = 8'h08;
        clear = 1'b1;
        array = '0;
        start = 1'b0;
        ready = 1'b0;
        test_reset();
        test_full_stream();
        test_backpressure();
        test_snapshot();
        test_back_to_back();
        test_clear_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
